// File: rtl/mux_pkg.sv
// Shared definitions for the 16-slot TDM mux/demux pair.
// The state encoding is common to the transmitter and the receiver.
package mux_pkg;

    localparam int N     = 16;
    localparam int SEL_W = $clog2(N);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } tdm_state_e;

endpackage

// File: rtl/demux_1x16_tdm_if.sv
// Serial-in / parallel-out bundle between a TDM link and the 16-line demux.
// The master drives the serial side; the slave is the demux.
interface demux_1x16_tdm_if
    import mux_pkg::*;
#(
    parameter int N     = mux_pkg::N,
    parameter int SEL_W = $clog2(N)
);

    logic             din;
    logic             din_valid;
    logic             frame_start;
    logic [N-1:0]     out;
    logic [SEL_W-1:0] sel;
    logic             word_valid;
    logic             busy;
    logic             frame_err;

    modport master (
        output din,
        output din_valid,
        output frame_start,
        input  out,
        input  sel,
        input  word_valid,
        input  busy,
        input  frame_err
    );

    modport slave (
        input  din,
        input  din_valid,
        input  frame_start,
        output out,
        output sel,
        output word_valid,
        output busy,
        output frame_err
    );

endinterface

// File: rtl/demux_1x16_tdm_slot_counter.sv
// Mod-N slot index with synchronous clear, load-to-1 and increment.
// Priority: clear, then load, then increment; o_last flags slot N-1.
module slot_counter
    import mux_pkg::*;
#(
    parameter int N     = mux_pkg::N,
    parameter int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load1,
    input  logic             i_inc,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_last
);

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N - 1);

    logic [SEL_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load1) begin
            r_cnt <= SEL_W'(1);
        end else if (i_inc) begin
            r_cnt <= (r_cnt == LAST_SLOT) ? '0 : r_cnt + SEL_W'(1);
        end
    end

    assign o_sel  = r_cnt;
    assign o_last = (r_cnt == LAST_SLOT);

endmodule

// File: rtl/demux_1x16_tdm.sv
// 1:16 TDM demux: steers serial slot bits into a shadow word and publishes
// the completed word with a one-cycle strobe; early frame_start aborts.
module demux_1x16_tdm
    import mux_pkg::*;
#(
    parameter int N     = mux_pkg::N,
    parameter int SEL_W = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    demux_1x16_tdm_if.slave       bus
);

    tdm_state_e       r_state;
    tdm_state_e       w_state_nxt;

    logic [SEL_W-1:0] w_sel;
    logic             w_last;

    logic             w_start;
    logic             w_abort;
    logic             w_shift;
    logic             w_done;

    logic [N-2:0]     r_shadow;
    logic [N-1:0]     r_out;
    logic             r_word_valid;
    logic             r_frame_err;

    slot_counter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_slot_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_done),
        .i_load1 (w_start | w_abort),
        .i_inc   (w_shift),
        .o_sel   (w_sel),
        .o_last  (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns it and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.din_valid && bus.frame_start) begin
                    w_state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.din_valid && !bus.frame_start && w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_start = 1'b0;
        w_abort = 1'b0;
        w_shift = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            IDLE: begin
                w_start = bus.din_valid && bus.frame_start;
            end
            COLLECT: begin
                if (bus.din_valid) begin
                    if (bus.frame_start) begin
                        w_abort = 1'b1;
                    end else if (w_last) begin
                        w_done = 1'b1;
                    end else begin
                        w_shift = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // The last slot bit goes straight to out, so the shadow holds only N-1 bits.
    always_ff @(posedge clk) begin
        // NOTE: the shadow is a handful of flops with a defined reset value; a deep RAM would not be reset.
        if (rst) begin
            r_shadow <= '0;
        end else begin
            if (w_start || w_abort) begin
                r_shadow[0] <= bus.din;
            end
            for (int j = 0; j < N - 1; j++) begin
                if (w_shift && (w_sel == SEL_W'(j))) begin
                    r_shadow[j] <= bus.din;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out        <= '0;
            r_word_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            if (w_done) begin
                r_out <= {bus.din, r_shadow};
            end
            r_word_valid <= w_done;
            r_frame_err  <= w_abort;
        end
    end

    assign bus.out        = r_out;
    assign bus.sel        = w_sel;
    assign bus.word_valid = r_word_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.busy       = (r_state == COLLECT);

    a_pulses_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(r_word_valid && r_frame_err));

    a_busy_sel_nonzero: assert property (@(posedge clk) disable iff (rst)
        (r_state == COLLECT) |-> (w_sel != '0));

    a_idle_sel_zero: assert property (@(posedge clk) disable iff (rst)
        (r_state == IDLE) |-> (w_sel == '0));

endmodule

// File: doc/demux_1x16_tdm.md
Name: demux_1x16_tdm

Overview:
- Receive-side counterpart of the team's 16:1 mux used as a time-division serialiser.
- The transmitter sweeps `sel` 0..15 and sends `in[sel]` one bit per slot. This block takes that serial bit stream, steers each bit to output line `sel`, and reassembles the 16-bit word.
- It presents the completed word with a one-cycle valid strobe.
- It sits between the serial link and any parallel consumer.

Parameters:
- N, 16, number of output lines / slots per frame
- SEL_W, 4, slot index width, equal to clog2(N)

Ports:
- clk  input  1  single system clock, rising edge
- rst  input  1  reset: synchronous, active-high
- din  input  1  serial data bit for the current slot
- din_valid  input  1  din is valid this cycle and is consumed
- frame_start  input  1  qualifies din as slot 0 of a new frame; only meaningful when din_valid=1
- out  output  N  last completed word; bit j = bit received in slot j
- sel  output  SEL_W  slot index the next accepted bit will be written to
- word_valid  output  1  one-cycle pulse: out updated this cycle
- busy  output  1  frame in progress (state COLLECT)
- frame_err  output  1  one-cycle pulse: a frame was aborted

Behaviour:
- Reset (rst=1 at a clk edge):
  - out=0, sel=0, word_valid=0, busy=0, frame_err=0.
  - The shadow register is cleared and the state goes to IDLE.
  - rst has priority over every other input, including mid-frame; the partial frame is discarded without frame_err.
- State IDLE:
  - din_valid=1 with frame_start=1: shadow[0]<=din, sel<=1, go to COLLECT.
  - din_valid=1 with frame_start=0: bit is ignored and the state stays IDLE (no error; link idle or unsynchronised).
- State COLLECT:
  - din_valid=0: hold all state; gaps of any length are allowed.
  - din_valid=1, frame_start=0, sel<N-1: shadow[sel]<=din, sel<=sel+1.
  - din_valid=1, frame_start=0, sel==N-1:
    - out<={din, shadow[N-2:0]} and word_valid=1 on the same edge.
    - sel wraps to 0 and the state goes to IDLE.
  - din_valid=1 with frame_start=1 (early restart):
    - frame_err=1 for one cycle and out is unchanged.
    - The shadow is reloaded as a new frame: shadow[0]<=din, sel<=1, and the state stays COLLECT.
- Back-to-back frames:
  - A frame_start bit in the cycle immediately after the slot-15 bit is accepted from IDLE.
  - Zero dead cycles are required between frames.
- Latency:
  - word_valid and the new out are registered and visible the cycle after the edge that accepts the slot-15 bit.
  - out holds its value until the next completed frame.
- Outputs: word_valid and frame_err are registered pulses, high for exactly one cycle, and never high together. busy = (state==COLLECT).
- Unused bits: shadow bits from an aborted frame never reach out.

Decomposition:
- Shared package (mux_pkg) holds:
  - N/SEL_W defaults;
  - state enum constants IDLE=1'b0, COLLECT=1'b1, shared with a future mux_16x1 TDM transmitter.
- One natural sub-module: slot_counter, a mod-N counter with synchronous clear, load-to-1 and increment enable. It provides sel and the last-slot flag.
- The demux core keeps the FSM, shadow register and output register.

Test Plan:
- Reset mid-frame: stream 7 bits, assert rst for 1 cycle -> out=0, sel=0, busy=0, no frame_err. A following full frame decodes normally.
- Sequential frame (transmitter-style sweep): in=43160 (16'hA898), send din=in[j] for j=0..15 with frame_start on j=0 and din_valid=1 every cycle -> word_valid pulse one cycle after slot 15, out=16'hA898, sel returns to 0.
- Gapped frame: same 16'hA898 with din_valid dropped for 3 cycles after slots 4 and 11 -> same out=16'hA898, exactly one word_valid, sel holds during gaps.
- Back-to-back frames: 16'hA898 then immediately 16'h5767 -> word_valid pulses 16 cycles apart, out=16'hA898 then 16'h5767.
- Early restart: 9 bits of 16'hFFFF, then frame_start with a full 16'h0001 frame -> one frame_err pulse at the restart, no word_valid for the aborted frame, final out=16'h0001.
- Idle garbage: din_valid=1 with frame_start=0 for 20 cycles in IDLE -> busy=0, sel=0, out unchanged, no pulses.
